// File: rtl/dmem_responder.sv
// Processor data-memory responder: synchronous-read word RAM plus MMIO cycle
// counter, output port, transmit FIFO and sticky overflow status.
module dmem_responder #(
    parameter int unsigned ADDR_BITS  = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] port_out,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_BITS;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

    localparam logic [31:0] ADDR_CYCLES = 32'h0000_1000;
    localparam logic [31:0] ADDR_PORT   = 32'h0000_1001;
    localparam logic [31:0] ADDR_TXQ    = 32'h0000_1002;
    localparam logic [31:0] ADDR_STATUS = 32'h0000_1003;

    logic [31:0]      ram [RAM_WORDS];
    logic [31:0]      fifo_mem [FIFO_DEPTH];

    logic [31:0]      cycles;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             sel_cycles_c;
    logic             sel_port_c;
    logic             sel_txq_c;
    logic             sel_status_c;
    logic             sel_ram_c;
    logic [ADDR_BITS-1:0] ram_idx_c;

    logic             full_c;
    logic             empty_c;
    logic             pop_c;
    logic             push_req_c;
    logic             push_c;
    logic             ovf_set_c;
    logic             ovf_clr_c;
    logic             ram_we_c;
    logic             port_we_c;

    logic [PTR_W-1:0] wr_ptr_n_c;
    logic [PTR_W-1:0] rd_ptr_n_c;
    logic [CNT_W-1:0] count_n_c;
    logic             ovf_n_c;
    logic [31:0]      head_n_c;
    logic [31:0]      status_c;
    logic [31:0]      rd_data_c;

    // Address decode; MMIO takes priority should the RAM window ever overlap it.
    always_comb begin
        sel_cycles_c = (address_dmem == ADDR_CYCLES);
        sel_port_c   = (address_dmem == ADDR_PORT);
        sel_txq_c    = (address_dmem == ADDR_TXQ);
        sel_status_c = (address_dmem == ADDR_STATUS);
        sel_ram_c    = ((address_dmem >> ADDR_BITS) == 32'd0)
                       && !(sel_cycles_c || sel_port_c || sel_txq_c || sel_status_c);
        ram_idx_c    = address_dmem[ADDR_BITS-1:0];
    end

    // FIFO, status and store-enable next-state logic.
    always_comb begin
        full_c     = (count == CNT_W'(FIFO_DEPTH));
        empty_c    = (count == '0);
        pop_c      = tx_valid & tx_ready;
        push_req_c = wren & sel_txq_c & reset;
        push_c     = push_req_c & (~full_c | pop_c);
        ovf_set_c  = push_req_c & full_c & ~pop_c;
        ovf_clr_c  = wren & sel_status_c & data[8];
        ram_we_c   = wren & sel_ram_c & reset;
        port_we_c  = wren & sel_port_c;

        wr_ptr_n_c = wr_ptr;
        rd_ptr_n_c = rd_ptr;
        count_n_c  = count;
        if (push_c) begin
            wr_ptr_n_c = wr_ptr + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_n_c = rd_ptr + PTR_W'(1);
        end
        if (push_c && !pop_c) begin
            count_n_c = count + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_n_c = count - CNT_W'(1);
        end

        // A set at the same edge as a clear wins so no overflow is ever missed.
        ovf_n_c = ovf;
        if (ovf_set_c) begin
            ovf_n_c = 1'b1;
        end else if (ovf_clr_c) begin
            ovf_n_c = 1'b0;
        end

        // The next head is the incoming word when it lands on the new read pointer.
        head_n_c = '0;
        if (count_n_c != '0) begin
            if (push_c && (wr_ptr == rd_ptr_n_c)) begin
                head_n_c = data;
            end else begin
                head_n_c = fifo_mem[rd_ptr_n_c];
            end
        end

        status_c = {23'b0, ovf, full_c, empty_c, 1'b0, 5'(count)};
    end

    // Read-data mux evaluated on pre-edge state, giving read-before-write.
    always_comb begin
        rd_data_c = '0;
        if (sel_cycles_c) begin
            rd_data_c = cycles;
        end else if (sel_port_c) begin
            rd_data_c = port_out;
        end else if (sel_status_c) begin
            rd_data_c = status_c;
        end else if (sel_ram_c) begin
            rd_data_c = ram[ram_idx_c];
        end
    end

    // RAM array is not reset so its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (ram_we_c) begin
            ram[ram_idx_c] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem   <= '0;
            port_out <= '0;
            cycles   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            q_dmem   <= rd_data_c;
            cycles   <= cycles + 32'd1;
            wr_ptr   <= wr_ptr_n_c;
            rd_ptr   <= rd_ptr_n_c;
            count    <= count_n_c;
            ovf      <= ovf_n_c;
            tx_data  <= head_n_c;
            tx_valid <= (count_n_c != '0);
            if (port_we_c) begin
                port_out <= data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, MMIO registers, TX FIFO and reset.
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [31:0] port_out;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int tests;
    int fails;

    dmem_responder #(.ADDR_BITS(12), .FIFO_DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .port_out     (port_out),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        address_dmem = a;
        wren         = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] c0;
        tests        = 0;
        fails        = 0;
        reset        = 1'b0;
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        tx_ready     = 1'b0;

        #2;
        check("rst_q",        q_dmem,          32'h0);
        check("rst_port",     port_out,        32'h0);
        check("rst_txvalid",  32'(tx_valid),   32'h0);
        check("rst_txdata",   tx_data,         32'h0);
        tick();
        tick();
        reset = 1'b1;

        // First edge after release counts 0->1; the read returns the pre-edge value.
        rd(32'h1000);
        c0 = q_dmem;
        check("cycles_first", c0, 32'h0);
        rd(32'h1000);
        check("cycles_diff", q_dmem - c0, 32'h1);

        wr(32'd6, 32'h1234_5678);
        wr(32'd5, 32'hDEAD_BEEF);
        rd(32'd5);
        check("ram_load5", q_dmem, 32'hDEAD_BEEF);
        rd(32'd6);
        check("ram_load6", q_dmem, 32'h1234_5678);
        rd(32'h2000);
        check("unmapped_2000", q_dmem, 32'h0);
        wr(32'h1004, 32'hFFFF_FFFF);
        rd(32'h1004);
        check("unmapped_1004", q_dmem, 32'h0);

        wr(32'd7, 32'h11);
        address_dmem = 32'd7;
        data         = 32'h22;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
        check("rbw_old", q_dmem, 32'h11);
        rd(32'd7);
        check("rbw_new", q_dmem, 32'h22);

        wr(32'h1001, 32'hA5);
        check("port_out", port_out, 32'hA5);
        rd(32'h1001);
        check("port_read", q_dmem, 32'hA5);
        rd(32'h1002);
        check("txq_read", q_dmem, 32'h0);
        check("txq_read_nopush", 32'(tx_valid), 32'h0);
        rd(32'h1003);
        check("status_empty", q_dmem, 32'h40);

        // Fill with consumer stalled, fifth push overflows.
        for (int i = 1; i <= 5; i++) begin
            wr(32'h1002, 32'(i));
        end
        check("fill_valid", 32'(tx_valid), 32'h1);
        check("fill_head", tx_data, 32'h1);
        rd(32'h1003);
        check("status_ovf_full", q_dmem, 32'h184);

        tx_ready     = 1'b1;
        address_dmem = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", 32'(tx_valid), 32'h1);
            check("drain_data", tx_data, 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("drained_valid", 32'(tx_valid), 32'h0);
        check("drained_data", tx_data, 32'h0);
        rd(32'h1003);
        check("status_drained", q_dmem, 32'h140);
        wr(32'h1003, 32'h100);
        rd(32'h1003);
        check("status_cleared", q_dmem, 32'h40);

        // Push while full and popping: accepted, no overflow.
        for (int i = 10; i <= 13; i++) begin
            wr(32'h1002, 32'(i));
        end
        rd(32'h1003);
        check("status_full", q_dmem, 32'h84);
        tx_ready = 1'b1;
        wr(32'h1002, 32'd9);
        tx_ready = 1'b0;
        check("pushpop_head", tx_data, 32'd11);
        rd(32'h1003);
        check("status_pushpop", q_dmem, 32'h84);
        tx_ready     = 1'b1;
        address_dmem = 32'h0;
        check("pp_out0", tx_data, 32'd11);
        tick();
        check("pp_out1", tx_data, 32'd12);
        tick();
        check("pp_out2", tx_data, 32'd13);
        tick();
        check("pp_out3", tx_data, 32'd9);
        tick();
        tx_ready = 1'b0;
        check("pp_empty", 32'(tx_valid), 32'h0);

        // Overflow flag is sticky until a store with bit 8 set.
        for (int i = 1; i <= 5; i++) begin
            wr(32'h1002, 32'(i));
        end
        wr(32'h1003, 32'h0);
        rd(32'h1003);
        check("ovf_noclear", q_dmem, 32'h184);
        wr(32'h1003, 32'h100);
        rd(32'h1003);
        check("ovf_clear", q_dmem, 32'h84);
        wr(32'h1002, 32'd6);
        rd(32'h1003);
        check("ovf_reset_pre", q_dmem, 32'h184);

        // Asynchronous reset mid-operation.
        reset = 1'b0;
        #1;
        check("arst_port", port_out, 32'h0);
        check("arst_txvalid", 32'(tx_valid), 32'h0);
        check("arst_txdata", tx_data, 32'h0);
        check("arst_q", q_dmem, 32'h0);
        tick();
        reset = 1'b1;
        rd(32'h1000);
        check("arst_cycles", q_dmem, 32'h0);
        rd(32'h1003);
        check("arst_status", q_dmem, 32'h40);
        rd(32'd5);
        check("arst_ram_kept", q_dmem, 32'hDEAD_BEEF);
        rd(32'h1001);
        check("arst_port_read", q_dmem, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12, sets RAM depth to 2^ADDR_BITS 32-bit words.
REQ-002 Parameter FIFO_DEPTH, default 4, sets output FIFO entries; power of two, 2..16.
REQ-003 clock  input  1  Single clock; all state updates on the rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset.
REQ-005 address_dmem  input  32  Word address from the processor memory stage.
REQ-006 data  input  32  Store data from the processor.
REQ-007 wren  input  1  Store enable; high for exactly the store's memory-stage cycle.
REQ-008 q_dmem  output  32  Read data returned to the processor.
REQ-009 port_out  output  32  Memory-mapped output port register.
REQ-010 tx_data  output  32  Head entry of the output FIFO.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  Consumer accepts the head entry when tx_valid & tx_ready at a rising edge.

Function
REQ-013 The address map SHALL be as follows: RAM at word addresses 0..2^ADDR_BITS-1; MMIO at 0x1000 CYCLES (RO), 0x1001 PORT (R/W), 0x1002 TXQ (WO), 0x1003 STATUS (RO/W1C). All other addresses read 0, and stores to them are ignored.
REQ-014 Reads SHALL be synchronous: q_dmem after rising edge N reflects the address at edge N, so it is stable before the processor's falling-edge MW latch.
REQ-015 A RAM store SHALL write data at the rising edge where wren=1; reading that address at the next edge returns the new value.
REQ-016 When read and write hit the same word at the same edge, q_dmem SHALL return the old value (read-before-write).
REQ-017 CYCLES SHALL be a 32-bit free-running counter, +1 every edge, wrapping 0xFFFFFFFF->0; stores to it are ignored.
REQ-018 Stores to PORT SHALL update port_out at that edge; reads return the current port_out.
REQ-019 A store to TXQ SHALL push data into the FIFO when not full; when full, the data is dropped and STATUS.ovf is set.
REQ-020 A pop SHALL occur on tx_valid & tx_ready; tx_data shows the head entry, first-in first-out.
REQ-021 A simultaneous push and pop SHALL succeed when the FIFO is full or non-empty; the count is unchanged and no overflow is flagged.
REQ-022 Push and pop pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-023 STATUS read SHALL return {23'b0, ovf[8], full[7], empty[6], 1'b0, count[4:0]}.
REQ-024 A STATUS store with data[8]=1 SHALL clear ovf; if an overflow occurs at the same edge, ovf stays 1.
REQ-025 Reads of TXQ SHALL return 0 and have no side effects.
REQ-026 The block SHALL raise no errors; misaligned or unmapped accesses are silently handled per REQ-013.

Reset
REQ-027 While reset=0: q_dmem=0, port_out=0, CYCLES=0, FIFO empty (tx_valid=0), tx_data=0, ovf=0, all immediately and asynchronously.
REQ-028 RAM contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-operation SHALL discard FIFO contents; a store at the same edge is lost.
REQ-030 After reset deassertion, the first rising edge SHALL count CYCLES 0->1.

Verification
REQ-031 The bench SHALL cover RAM store/load: store 0xDEADBEEF to addr 5, then load addr 5 next cycle -> q_dmem=0xDEADBEEF; load addr 6 -> prior contents; load addr 0x2000 -> 0.
REQ-032 The bench SHALL cover same-edge read/write: addr 7 holds 0x11 and a store of 0x22 to addr 7 -> q_dmem=0x11 that cycle, 0x22 on the next read.
REQ-033 The bench SHALL cover FIFO fill/overflow: tx_ready=0, push 1,2,3,4,5 to 0x1002 -> STATUS=0x180|4 (ovf, full, count 4); then tx_ready=1 -> tx_data sequence 1,2,3,4, then tx_valid=0 and STATUS=0x140.
REQ-034 The bench SHALL cover push+pop when full: FIFO full, tx_ready=1, push 9 -> count stays 4, ovf stays 0, 9 emerges last.
REQ-035 The bench SHALL cover ovf clear race: store 0x100 to STATUS at the same edge as an overflowing push -> ovf=1; a later clear with no push -> ovf=0.
REQ-036 The bench SHALL cover CYCLES/PORT/reset: read CYCLES on two consecutive cycles -> difference 1; store 0xA5 to PORT -> port_out=0xA5; pulse reset low -> port_out=0, tx_valid=0, CYCLES=0, RAM addr 5 still 0xDEADBEEF.
